// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I size codes,
// response error codes and the request legality check.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DATA,
    ST_WRITE
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_FAULT    = 2'b10;
  localparam logic [1:0] ERR_FUNCT3   = 2'b11;

  // Priority: illegal size code, then misalignment, then out-of-range word address.
  function automatic logic [1:0] req_check(input logic             we,
                                           input logic [2:0]       funct3,
                                           input logic [XLEN-1:0]  addr,
                                           input logic [XLEN-1:0]  max_word);
    logic       legal;
    logic [1:0] err;
    legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
            (!we && ((funct3 == F3_BU) || (funct3 == F3_HU)));
    err = ERR_OK;
    if (!legal) begin
      err = ERR_FUNCT3;
    end else if (((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3 == F3_W) && (addr[1:0] != 2'b00))) begin
      err = ERR_MISALIGN;
    end else if ({addr[XLEN-1:2], 2'b00} > max_word) begin
      err = ERR_FAULT;
    end
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: extracts and extends the addressed load lane, and merges
// sub-word store data into the word read back from memory.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merge_data
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c     = rdata[{offset, 3'b000} +: 8];
    half_c     = rdata[{offset[1], 4'b0000} +: 16];
    load_data  = rdata;
    merge_data = wdata;
    case (funct3)
      F3_B:    load_data = {{24{byte_c[7]}}, byte_c};
      F3_H:    load_data = {{16{half_c[15]}}, half_c};
      F3_BU:   load_data = {24'd0, byte_c};
      F3_HU:   load_data = {16'd0, half_c};
      default: load_data = rdata;
    endcase
    // Read-modify-write: only the addressed lane takes the new store data.
    if (funct3 == F3_B) begin
      merge_data = rdata;
      merge_data[{offset, 3'b000} +: 8] = wdata[7:0];
    end else if (funct3 == F3_H) begin
      merge_data = rdata;
      merge_data[{offset[1], 4'b0000} +: 16] = wdata[15:0];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time against a single-port, one-cycle-latency
// word memory; sub-word stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic [1:0]      resp_err,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_write_data,
  output logic            mem_write,
  input  logic [XLEN-1:0] mem_read_data
);

  localparam logic [XLEN-1:0] MAX_WORD = XLEN'(MEM_BYTES - 4);

  state_t          state;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] wword_q;
  logic [1:0]      req_err_c;
  logic [XLEN-1:0] load_data_c;
  logic [XLEN-1:0] merge_data_c;

  assign req_ready      = (state == ST_IDLE);
  assign mem_address    = {addr_q[XLEN-1:2], 2'b00};
  assign mem_write_data = wword_q;
  assign mem_write      = (state == ST_WRITE);
  assign req_err_c      = req_check(req_we, req_funct3, req_addr, MAX_WORD);

  lsu_align u_align (
    .funct3     (funct3_q),
    .offset     (addr_q[1:0]),
    .rdata      (mem_read_data),
    .wdata      (wdata_q),
    .load_data  (load_data_c),
    .merge_data (merge_data_c)
  );

  // Request sequencing and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wword_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= ERR_OK;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            if (req_err_c != ERR_OK) begin
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              resp_err   <= req_err_c;
            end else if (req_we && (req_funct3 == F3_W)) begin
              wword_q <= req_wdata;
              state   <= ST_WRITE;
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_READ: state <= ST_DATA;
        ST_DATA: begin
          if (we_q) begin
            wword_q <= merge_data_c;
            state   <= ST_WRITE;
          end else begin
            resp_valid <= 1'b1;
            resp_rdata <= load_data_c;
            resp_err   <= ERR_OK;
            state      <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          resp_err   <= ERR_OK;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized traffic
// against a byte-array reference memory.
module tb_load_store_unit;

  localparam int unsigned MEM_BYTES = 1024;
  localparam int unsigned WORDS     = MEM_BYTES / 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic [31:0] mem_read_data;

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  // Data memory attached to the DUT, and the byte-level reference image.
  logic [31:0] mem  [WORDS];
  logic [7:0]  rmem [MEM_BYTES];
  int unsigned wr_cnt = 0;
  int unsigned cyc    = 0;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always @(posedge clk) begin
    cyc++;
    if (mem_write) begin
      mem[mem_address[9:2]] <= mem_write_data;
      wr_cnt++;
    end
    mem_read_data <= mem[mem_address[9:2]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int unsigned size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [1:0] model_err(input logic we, input logic [2:0] f3,
                                           input logic [31:0] a);
    int unsigned sz;
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 || (we && f3[2])) return 2'b11;
    sz = size_of(f3);
    if ((a % sz) != 0) return 2'b01;
    if ((a - (a % 4)) > MEM_BYTES - 4) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int unsigned sz;
    logic [31:0] v;
    sz = size_of(f3);
    v  = 32'd0;
    for (int k = 0; k < int'(sz); k++) v = v | (32'(rmem[int'(a) + k]) << (8 * k));
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < int'(size_of(f3)); k++) rmem[int'(a) + k] = d[8*k +: 8];
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  // One complete transaction: issue, scramble inputs while busy, then check the response.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input string tag, output logic [31:0] got);
    logic [1:0]  e;
    logic [31:0] er;
    int          exp_lat;
    int          lat;
    int unsigned w0;
    e       = model_err(we, f3, a);
    er      = (e == 2'b00 && !we) ? model_load(f3, a) : 32'd0;
    exp_lat = (e != 2'b00) ? 1 : (we ? ((f3 == 3'b010) ? 2 : 4) : 3);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    wait_ready(tag);
    w0 = wr_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 10);
    got = resp_rdata;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, 32'(resp_err), 32'(e));
    check({tag, "_rdata"}, resp_rdata, er);
    check({tag, "_writes"}, wr_cnt - w0, (e == 2'b00 && we) ? 32'd1 : 32'd0);
    if (e == 2'b00 && we) model_store(f3, a, d);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(resp_valid), 32'd0);
  endtask

  logic [31:0] r;
  logic [31:0] bb_addr [5];
  logic [31:0] bb_exp  [5];
  int unsigned acc_cyc;
  int unsigned w0;
  int          n;
  int unsigned bad;

  initial begin
    for (int i = 0; i < int'(WORDS); i++) begin
      mem[i] = $urandom;
      for (int k = 0; k < 4; k++) rmem[4*i + k] = mem[i][8*k +: 8];
    end
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    rst_n = 1'b1;

    run_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, "sw10", r);
    run_req(1'b0, 3'b010, 32'h10, 32'h0, "lw10", r);
    check("lw10_const", r, 32'hDEAD_BEEF);
    run_req(1'b1, 3'b000, 32'h12, 32'h0000_0055, "sb12", r);
    run_req(1'b0, 3'b010, 32'h10, 32'h0, "lw10b", r);
    check("lw10b_const", r, 32'hDE55_BEEF);
    run_req(1'b0, 3'b000, 32'h13, 32'h0, "lb13", r);
    check("lb13_const", r, 32'hFFFF_FFDE);
    run_req(1'b0, 3'b100, 32'h13, 32'h0, "lbu13", r);
    check("lbu13_const", r, 32'h0000_00DE);
    run_req(1'b1, 3'b001, 32'h20, 32'h0000_8001, "sh20", r);
    run_req(1'b0, 3'b001, 32'h20, 32'h0, "lh20", r);
    check("lh20_const", r, 32'hFFFF_8001);
    run_req(1'b0, 3'b101, 32'h20, 32'h0, "lhu20", r);
    check("lhu20_const", r, 32'h0000_8001);
    run_req(1'b1, 3'b001, 32'h21, 32'h1234, "sh21_mis", r);
    run_req(1'b0, 3'b010, 32'h400, 32'h0, "lw400_fault", r);
    run_req(1'b0, 3'b011, 32'h10, 32'h0, "f3_011", r);
    run_req(1'b0, 3'b000, 32'h3FF, 32'h0, "lb_top", r);
    run_req(1'b1, 3'b100, 32'h8, 32'h0, "sbu_illegal", r);

    // Reset while a byte store sits in DATA: no write may reach memory.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h30; req_wdata = 32'hA5;
    wait_ready("rst_sb");
    w0 = wr_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(req_ready), 32'd1);
    check("midrst_mem_write", 32'(mem_write), 32'd0);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_mem_address", mem_address, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_write", wr_cnt - w0, 32'd0);
    run_req(1'b0, 3'b010, 32'h30, 32'h0, "lw30_after_rst", r);

    // Back-to-back loads with req_valid held high.
    for (int i = 0; i < 5; i++) begin
      bb_addr[i] = 32'(4 * $urandom_range(0, WORDS - 1));
      bb_exp[i]  = model_load(3'b010, bb_addr[i]);
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = bb_addr[0];
    acc_cyc = 0;
    for (int i = 0; i < 5; i++) begin
      wait_ready("b2b");
      if (i > 0) begin
        check("b2b_resp_valid", 32'(resp_valid), 32'd1);
        check("b2b_rdata", resp_rdata, bb_exp[i-1]);
        check("b2b_gap", cyc - acc_cyc, 32'd3);
      end
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      if (i < 4) req_addr = bb_addr[i+1];
      else req_valid = 1'b0;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 10);
    check("b2b_last_rdata", resp_rdata, bb_exp[4]);

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      logic [31:0] a;
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = $urandom;
      else if (sel == 1) a = MEM_BYTES + $urandom_range(0, 15);
      else               a = $urandom_range(0, MEM_BYTES - 1);
      run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, "rnd", r);
    end

    bad = 0;
    for (int i = 0; i < int'(WORDS); i++)
      if (mem[i] !== {rmem[4*i+3], rmem[4*i+2], rmem[4*i+1], rmem[4*i]}) bad++;
    check("mem_image", bad, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
